pressure_alarm_controller: RTL and testbench
============================================

Name: pressure_alarm_controller

Overview:
- Downstream consumer of the pressure abnormality flag produced by the pressure abnormality detector.
- Filters the per-sample flag with a consecutive-sample persistence check and raises a registered alarm.
- The alarm is silenced by an operator acknowledge. The block clears only after a sustained run of normal samples.
- Also keeps a saturating count of alarm events for the display and status logic.

Parameters:
- TRIGGER_COUNT, 4: consecutive valid abnormal samples required to raise the alarm (legal range 1..15).
- CLEAR_COUNT, 8: consecutive valid normal samples required to clear (legal range 1..15).
- CNT_W, 4: width of the streak and clear counters.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sampleValid  input  1  a new pressure sample's flag is present this cycle.
- pressureAbnormality  input  1  detector output; 1 = abnormal sample (parity error and analyzer fault). Sampled only when sampleValid=1.
- alarmAck  input  1  operator acknowledge, single-cycle or level; acted on only in ALARM.
- alarm  output  1  buzzer/indicator drive; 1 only in ALARM.
- alarmLatched  output  1  1 in ALARM or SILENCED.
- state  output  2  NORMAL=0, SUSPECT=1, ALARM=2, SILENCED=3.
- eventCount  output  8  number of NORMAL/SUSPECT->ALARM entries; saturates at 255.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: on rst=1 at a clock edge, state=NORMAL, alarm=0, alarmLatched=0, eventCount=0, streak=0, clearCnt=0. Reset overrides every other input and applies mid-operation, including in ALARM.
- All outputs are registered. alarm and alarmLatched are decoded from the registered state.
- Cycles with sampleValid=0 hold state and both counters unchanged. Invalid gaps do not break a streak.
- NORMAL:
  - valid & abnormal: streak=1. Go to ALARM if TRIGGER_COUNT=1, otherwise go to SUSPECT.
  - valid & normal: stay; streak=0.
- SUSPECT:
  - valid & abnormal: streak+1. When the new streak equals TRIGGER_COUNT, go to ALARM.
  - valid & normal: go to NORMAL; streak=0.
- Alarm latency: alarm=1 in the cycle after the clock edge that samples the TRIGGER_COUNT-th abnormal sample.
- ALARM entry: eventCount increments by 1 unless already 255; streak=0; clearCnt=0.
- ALARM:
  - valid & normal: clearCnt+1, saturating at CLEAR_COUNT.
  - valid & abnormal: clearCnt=0.
  - The block never leaves ALARM without alarmAck.
  - alarmAck=1: compute clearCnt' first, including any valid sample in the same cycle. If clearCnt'=CLEAR_COUNT, go to NORMAL; otherwise go to SILENCED.
- SILENCED:
  - alarm=0, alarmLatched=1.
  - valid & normal: clearCnt+1. When it reaches CLEAR_COUNT, go to NORMAL with clearCnt=0.
  - valid & abnormal: clearCnt=0; stay (no re-alarm, no eventCount change).
  - alarmAck is ignored.
- alarmAck in NORMAL or SUSPECT has no effect.
- Counter rules:
  - streak is meaningful only in NORMAL/SUSPECT. clearCnt is meaningful only in ALARM/SILENCED.
  - Both counters are forced to 0 on every state change.
  - Neither counter wraps.
- eventCount at 255 stays at 255 on further alarms. It is cleared only by rst.
- Each clock edge takes exactly one transition. A sample arriving on the same edge as a transition is consumed by the source state's rules.

Test Plan:
- Reset: drive rst=1 for 2 cycles with random inputs -> state=0, alarm=0, alarmLatched=0, eventCount=0.
- Sub-threshold burst: 3 valid abnormal samples, then 1 valid normal -> state 0->1->1->1->0; alarm never 1; eventCount=0.
- Trigger across gaps: 4 valid abnormal samples separated by 2 invalid cycles each -> alarm=1 the cycle after the 4th; state=2; eventCount=1.
- Silence and re-clear:
  - In ALARM, pulse alarmAck while abnormal persists -> state=3, alarm=0, alarmLatched=1.
  - Then 7 normal, 1 abnormal, 8 normal samples -> NORMAL only after the final 8th normal sample.
- Recover before ack:
  - In ALARM, 8 valid normal samples -> stays state=2, alarm=1.
  - Then alarmAck -> state=0 next cycle.
  - Repeat with alarmAck coincident with the 8th normal sample -> state=0 directly, SILENCED never entered.
- Saturation and mid-op reset:
  - Force 256 alarm events -> eventCount=255 and stays 255 on the 257th.
  - Assert rst while in ALARM -> next cycle state=0, alarm=0, eventCount=0.

Source files
------------

// File: rtl/pressure_alarm_controller.sv
// Persistence-filtered pressure alarm with operator silence, sustained-normal clear
// and a saturating alarm event counter.
module pressure_alarm_controller #(
  parameter int unsigned TRIGGER_COUNT = 4,
  parameter int unsigned CLEAR_COUNT   = 8,
  parameter int unsigned CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sampleValid,
  input  logic       pressureAbnormality,
  input  logic       alarmAck,
  output logic       alarm,
  output logic       alarmLatched,
  output logic [1:0] state,
  output logic [7:0] eventCount
);

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    SUSPECT  = 2'd1,
    ALARM    = 2'd2,
    SILENCED = 2'd3
  } stateT;

  localparam logic [CNT_W-1:0] TRIG_LIM  = CNT_W'(TRIGGER_COUNT);
  localparam logic [CNT_W-1:0] CLEAR_LIM = CNT_W'(CLEAR_COUNT);

  stateT            stateReg;
  logic [CNT_W-1:0] streak;
  logic [CNT_W-1:0] clearCnt;

  logic             validAbn;
  logic             validNorm;
  logic [CNT_W-1:0] streakInc;
  logic             hitTrigger;
  logic [CNT_W-1:0] clearNext;
  logic             clearDone;

  assign state     = stateReg;
  assign validAbn  = sampleValid & pressureAbnormality;
  assign validNorm = sampleValid & ~pressureAbnormality;

  // Streak is always 0 in NORMAL, so the first abnormal sample starts the run at 1.
  assign streakInc  = (stateReg == NORMAL) ? CNT_W'(1) : streak + CNT_W'(1);
  assign hitTrigger = (streakInc == TRIG_LIM);

  // Clear counter after this cycle's sample, saturating at the clear threshold.
  always_comb begin
    clearNext = clearCnt;
    if (validAbn) begin
      clearNext = '0;
    end else if (validNorm && (clearCnt != CLEAR_LIM)) begin
      clearNext = clearCnt + CNT_W'(1);
    end
  end
  assign clearDone = (clearNext == CLEAR_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg     <= NORMAL;
      alarm        <= 1'b0;
      alarmLatched <= 1'b0;
      eventCount   <= 8'd0;
      streak       <= '0;
      clearCnt     <= '0;
    end else begin
      case (stateReg)
        NORMAL, SUSPECT: begin
          if (validAbn) begin
            if (hitTrigger) begin
              stateReg     <= ALARM;
              alarm        <= 1'b1;
              alarmLatched <= 1'b1;
              streak       <= '0;
              clearCnt     <= '0;
              if (eventCount != 8'hFF) eventCount <= eventCount + 8'd1;
            end else begin
              stateReg <= SUSPECT;
              streak   <= streakInc;
            end
          end else if (validNorm) begin
            stateReg <= NORMAL;
            streak   <= '0;
          end
        end
        ALARM: begin
          if (alarmAck) begin
            stateReg     <= clearDone ? NORMAL : SILENCED;
            alarm        <= 1'b0;
            alarmLatched <= ~clearDone;
            clearCnt     <= '0;
            streak       <= '0;
          end else begin
            clearCnt <= clearNext;
          end
        end
        SILENCED: begin
          if (validNorm && clearDone) begin
            stateReg     <= NORMAL;
            alarmLatched <= 1'b0;
            clearCnt     <= '0;
            streak       <= '0;
          end else begin
            clearCnt <= clearNext;
          end
        end
        default: begin
          stateReg     <= NORMAL;
          alarm        <= 1'b0;
          alarmLatched <= 1'b0;
          streak       <= '0;
          clearCnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pressure_alarm_controller.sv
// Table-driven self-checking bench for pressure_alarm_controller with a queue scoreboard.
module tb_pressure_alarm_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sampleValid = 1'b0;
  logic       pressureAbnormality = 1'b0;
  logic       alarmAck = 1'b0;
  logic       alarm;
  logic       alarmLatched;
  logic [1:0] state;
  logic [7:0] eventCount;

  pressure_alarm_controller #(
    .TRIGGER_COUNT(4),
    .CLEAR_COUNT  (8),
    .CNT_W        (4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .sampleValid        (sampleValid),
    .pressureAbnormality(pressureAbnormality),
    .alarmAck           (alarmAck),
    .alarm              (alarm),
    .alarmLatched       (alarmLatched),
    .state              (state),
    .eventCount         (eventCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       v;
    logic       a;
    logic       k;
    logic [1:0] st;
    logic [7:0] ev;
  } vecT;

  vecT vecs[$];
  vecT expQ[$];
  int  errors = 0;
  int  checks = 0;
  int  stepNo = 0;
  int  expEvt;

  function automatic void addv(input logic r, input logic v, input logic a, input logic k,
                               input logic [1:0] st, input logic [7:0] ev);
    vecT t;
    t.r = r; t.v = v; t.a = a; t.k = k; t.st = st; t.ev = ev;
    vecs.push_back(t);
  endfunction

  function automatic void addn(input int n, input logic v, input logic a, input logic k,
                               input logic [1:0] st, input logic [7:0] ev);
    for (int i = 0; i < n; i++) addv(1'b0, v, a, k, st, ev);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, stepNo, act, exp);
    end
  endtask

  // Drive one cycle, queue its expectation, then compare just after the edge.
  task automatic step(input logic r, input logic v, input logic a, input logic k,
                      input logic [1:0] st, input logic [7:0] ev);
    vecT t;
    vecT e;
    @(negedge clk);
    rst = r; sampleValid = v; pressureAbnormality = a; alarmAck = k;
    t.r = r; t.v = v; t.a = a; t.k = k; t.st = st; t.ev = ev;
    expQ.push_back(t);
    @(posedge clk);
    #1;
    stepNo++;
    if (expQ.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      e = expQ.pop_front();
      check("state", int'(state), int'(e.st));
      check("alarm", int'(alarm), int'(e.st == 2'd2));
      check("alarmLatched", int'(alarmLatched), int'(e.st >= 2'd2));
      check("eventCount", int'(eventCount), int'(e.ev));
    end
  endtask

  initial begin
    // Reset with random inputs, then ack in NORMAL has no effect
    addv(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'd0, 8'd0);
    addv(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'd0, 8'd0);
    addv(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'd0);
    // Sub-threshold burst
    addn(3, 1'b1, 1'b1, 1'b0, 2'd1, 8'd0);
    addn(1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    // Trigger across invalid gaps (gap cycles carry abnormal=1 and ack that must be ignored)
    for (int i = 0; i < 3; i++) begin
      addn(1, 1'b1, 1'b1, 1'b0, 2'd1, 8'd0);
      addn(1, 1'b0, 1'b1, 1'b1, 2'd1, 8'd0);
      addn(1, 1'b0, 1'b0, 1'b0, 2'd1, 8'd0);
    end
    addn(1, 1'b1, 1'b1, 1'b0, 2'd2, 8'd1);
    addn(1, 1'b0, 1'b0, 1'b0, 2'd2, 8'd1);
    // Silence while abnormal persists, then 7 normal, 1 abnormal, 8 normal
    addn(1, 1'b1, 1'b1, 1'b1, 2'd3, 8'd1);
    addn(3, 1'b1, 1'b0, 1'b0, 2'd3, 8'd1);
    addn(1, 1'b1, 1'b0, 1'b1, 2'd3, 8'd1);
    addn(3, 1'b1, 1'b0, 1'b0, 2'd3, 8'd1);
    addn(1, 1'b1, 1'b1, 1'b0, 2'd3, 8'd1);
    addn(7, 1'b1, 1'b0, 1'b0, 2'd3, 8'd1);
    addn(1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1);
    // Recover before ack: 8 normal in ALARM stays, then ack alone -> NORMAL
    addn(3, 1'b1, 1'b1, 1'b0, 2'd1, 8'd1);
    addn(1, 1'b1, 1'b1, 1'b0, 2'd2, 8'd2);
    addn(8, 1'b1, 1'b0, 1'b0, 2'd2, 8'd2);
    addn(1, 1'b0, 1'b0, 1'b1, 2'd0, 8'd2);
    // Ack coincident with the 8th normal sample -> NORMAL directly
    addn(3, 1'b1, 1'b1, 1'b0, 2'd1, 8'd2);
    addn(1, 1'b1, 1'b1, 1'b0, 2'd2, 8'd3);
    addn(7, 1'b1, 1'b0, 1'b0, 2'd2, 8'd3);
    addn(1, 1'b1, 1'b0, 1'b1, 2'd0, 8'd3);
    // Abnormal in ALARM restarts the clear run, so a later ack only silences
    addn(3, 1'b1, 1'b1, 1'b0, 2'd1, 8'd3);
    addn(1, 1'b1, 1'b1, 1'b0, 2'd2, 8'd4);
    addn(5, 1'b1, 1'b0, 1'b0, 2'd2, 8'd4);
    addn(1, 1'b1, 1'b1, 1'b0, 2'd2, 8'd4);
    addn(7, 1'b1, 1'b0, 1'b0, 2'd2, 8'd4);
    addn(1, 1'b0, 1'b0, 1'b1, 2'd3, 8'd4);
    addn(7, 1'b1, 1'b0, 1'b0, 2'd3, 8'd4);
    addn(1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd4);

    foreach (vecs[i]) step(vecs[i].r, vecs[i].v, vecs[i].a, vecs[i].k, vecs[i].st, vecs[i].ev);

    // Saturation: drive events 5..257 with a cheap trigger/clear cycle
    expEvt = 4;
    for (int n = 5; n <= 257; n++) begin
      for (int j = 0; j < 3; j++) step(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 8'(expEvt));
      expEvt = (expEvt >= 255) ? 255 : expEvt + 1;
      step(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 8'(expEvt));
      for (int j = 0; j < 7; j++) step(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'(expEvt));
      step(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 8'(expEvt));
    end
    check("eventCount_saturated", int'(eventCount), 255);

    // Mid-operation reset while in ALARM
    for (int j = 0; j < 3; j++) step(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 8'd255);
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 8'd255);
    step(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 8'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 8'd0);

    check("scoreboard_drained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
